stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
Hazard and stall sequencer for the 5-stage pipeline. It drives the IF/ID register enable, the PC enable and the ID/EX flush. It detects RAW hazards that forwarding cannot cover, using Tuse/Tnew classes. It also tracks the multi-cycle mult/div unit with a busy counter so that MD-class instructions are held in ID while that unit is busy. A saturating stall-cycle counter supports performance measurement.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu issues from EX
DIV_CYC, 10, busy cycles after a div/divu issues from EX
CNT_W, 4, width of the MD busy counter (must hold DIV_CYC)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
rs_D  in  5  ID-stage rs register number
rt_D  in  5  ID-stage rt register number
tuse_rs_D  in  2  cycles until rs is consumed (3 = not used)
tuse_rt_D  in  2  cycles until rt is consumed (3 = not used)
md_D  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
wa_E  in  5  EX-stage destination register (0 = none)
tnew_E  in  2  cycles until the EX result is available
wa_M  in  5  MEM-stage destination register (0 = none)
tnew_M  in  2  cycles until the MEM result is available
md_start_E  in  1  EX instruction starts mult/div this cycle
md_div_E  in  1  1 = div/divu, 0 = mult/multu (valid with md_start_E)
pc_en  out  1  PC register write enable
en01  out  1  IF/ID register enable
flush12  out  1  synchronous clear of the ID/EX register (inserts a bubble)
md_busy  out  1  MD unit busy this cycle
stall_cnt  out  32  saturating count of stall cycles since reset

Behaviour:
Data-hazard stall:
- stall_rs = (rs_D != 0) & ((rs_D == wa_E & tnew_E > tuse_rs_D) | (rs_D == wa_M & tnew_M > tuse_rs_D)).
- stall_rt uses the same equation with rt_D and tuse_rt_D.
- Comparisons are unsigned 2-bit.
- Register 0 never causes a stall.

MD busy counter (md_cnt, CNT_W bits):
- On reset: md_cnt = 0.
- If md_start_E is high: md_cnt loads DIV_CYC when md_div_E = 1, otherwise MULT_CYC. A start also wins over decrement and restarts the count if one is already running.
- Else if md_cnt != 0: md_cnt decrements by 1.
- md_busy = md_start_E | (md_cnt != 0), combinational.
- For a start in EX at cycle t, md_busy is high for cycles t through t+N, where N = MULT_CYC or DIV_CYC.

MD stall:
- stall_md = md_D & md_busy.

Combined outputs:
- stall = stall_rs | stall_rt | stall_md.
- pc_en = ~stall; en01 = ~stall; flush12 = stall. All are combinational, with zero latency.
- While reset is high, force pc_en = 1, en01 = 1 and flush12 = 1. The IF/ID register only applies its reset when its enable is high, so en01 must stay asserted during reset.

stall_cnt:
- On reset: 0.
- Increments by 1 on each clock edge where stall = 1 and reset = 0.
- Saturates at 0xFFFFFFFF and does not wrap.

Reset mid-operation:
- Clears md_cnt and stall_cnt on the next edge, regardless of an active start or stall.

Simultaneous events:
- A data stall and an MD stall in the same cycle count as a single stall cycle.
- md_start_E can coincide with md_D; the stall then begins in that same cycle.

Decomposition:
- Shared package holds:
  - Tuse/Tnew encodings: T0 = 0, T1 = 1, T2 = 2, TNONE = 3.
  - MULT_CYC and DIV_CYC default constants.
  - The reset PC constant 32'h00003000, used by the pipeline registers.
- One natural sub-module: md_busy_tracker, containing md_cnt and md_busy.
- The top level holds the hazard compare, the output logic and stall_cnt.

Test Plan:
- Reset: hold reset for 2 cycles -> en01 = 1, pc_en = 1, flush12 = 1, md_busy = 0; after release, stall_cnt = 0.
- Load-use hazard: rs_D = 8, tuse_rs_D = 0, wa_E = 8, tnew_E = 2 -> stall: pc_en = 0, en01 = 0, flush12 = 1. Then set wa_E = 0, wa_M = 8, tnew_M = 1 -> stall persists one more cycle. Then tnew_M = 0 -> no stall; stall_cnt = 2.
- $0 and forwardable cases: rs_D = 0, wa_E = 0, tnew_E = 2 -> no stall. rt_D = 9, tuse_rt_D = 1, wa_E = 9, tnew_E = 1 -> no stall (tnew not > tuse).
- Mult timing: md_start_E = 1, md_div_E = 0 at cycle t, with md_D = 1 held -> md_busy and stall high for cycles t..t+5, low at t+6; stall_cnt = 6.
- Div restart: a div start, then a second start 3 cycles later -> md_cnt reloads to 10; md_busy stays high 10 cycles past the second start.
- Reset mid-div: assert reset at md_cnt = 7 -> next cycle md_cnt = 0, md_busy = 0, stall_cnt = 0. Saturation: preload stall_cnt near max (force), stall 3 cycles -> value holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall sequencer and pipeline registers.
// Tuse/Tnew classes, MD latencies, reset PC and the RAW-hazard helper.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        T0    = 2'd0,
        T1    = 2'd1,
        T2    = 2'd2,
        TNONE = 2'd3
    } tclass_e;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // Producer still in flight longer than the consumer can wait.
    function automatic logic raw_hazard(
        input logic [4:0] ra,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (ra == wa_e) && (tnew_e > tuse);
        hit_m = (ra == wa_m) && (tnew_m > tuse);
        return (ra != 5'd0) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_tracker.sv
// Busy window tracker for the multi-cycle mult/div unit.
// A start in EX (re)loads the latency; busy covers the start cycle too.
module md_busy_tracker
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_div_E,
    output logic md_busy
);

    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] load_val;

    assign load_val = md_div_E ? CNT_W'(DIV_CYC)
                               : CNT_W'(MULT_CYC);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start_E) begin
            md_cnt <= load_val;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign md_busy = md_start_E || (md_cnt != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall sequencer: drives PC/IF-ID enables and ID/EX flush.
// Holds RAW compare, MD-busy stall and a saturating stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_D,
    input  logic [4:0]  wa_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wa_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        pc_en,
    output logic        en01,
    output logic        flush12,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    md_busy_tracker #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md (
        .clk        (clk),
        .reset      (reset),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .md_busy    (md_busy)
    );

    assign stall_rs = raw_hazard(rs_D, tuse_rs_D,
                                 wa_E, tnew_E, wa_M, tnew_M);
    assign stall_rt = raw_hazard(rt_D, tuse_rt_D,
                                 wa_E, tnew_E, wa_M, tnew_M);
    assign stall_md = md_D && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;

    // IF/ID only resets when enabled, so keep it open during reset.
    always_comb begin
        pc_en   = ~stall;
        en01    = ~stall;
        flush12 = stall;
        if (reset) begin
            pc_en   = 1'b1;
            en01    = 1'b1;
            flush12 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares one entry per cycle.
module tb_stall_ctrl;
    import stall_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, wa_E, wa_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_D, md_start_E, md_div_E;
    logic        pc_en, en01, flush12, md_busy;
    logic [31:0] stall_cnt;

    typedef struct {
        string       name;
        logic        pc_en;
        logic        en01;
        logic        flush12;
        logic        md_busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_D       (md_D),
        .wa_E       (wa_E),
        .tnew_E     (tnew_E),
        .wa_M       (wa_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .pc_en      (pc_en),
        .en01       (en01),
        .flush12    (flush12),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %h want %h",
                     nm, fld, act, req);
        end
    endtask

    // Monitor: DUT presents a combinational result every cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "pc_en",   32'(pc_en),   32'(e.pc_en));
            chk(e.name, "en01",    32'(en01),    32'(e.en01));
            chk(e.name, "flush12", 32'(flush12), 32'(e.flush12));
            chk(e.name, "md_busy", 32'(md_busy), 32'(e.md_busy));
            chk(e.name, "cnt",     stall_cnt,    e.cnt);
        end
    end

    task automatic cyc(input string nm, input logic pe,
                       input logic en, input logic fl,
                       input logic bz, input logic [31:0] c);
        exp_t e;
        e.name    = nm;
        e.pc_en   = pe;
        e.en01    = en;
        e.flush12 = fl;
        e.md_busy = bz;
        e.cnt     = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_D = 5'd0; rt_D = 5'd0;
        tuse_rs_D = TNONE; tuse_rt_D = TNONE;
        wa_E = 5'd0; tnew_E = T0;
        wa_M = 5'd0; tnew_M = T0;
        md_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst0", 1, 1, 1, 0, 0);
        cyc("rst1", 1, 1, 1, 0, 0);
        reset = 1'b0;
        cyc("post_rst", 1, 1, 0, 0, 0);

        // Load-use: EX then MEM producer
        rs_D = 5'd8; tuse_rs_D = T0;
        wa_E = 5'd8; tnew_E = T2;
        cyc("lu_ex", 0, 0, 1, 0, 0);
        wa_E = 5'd0; wa_M = 5'd8; tnew_M = T1;
        cyc("lu_mem", 0, 0, 1, 0, 1);
        tnew_M = T0;
        cyc("lu_done", 1, 1, 0, 0, 2);

        // $0 and forwardable
        idle();
        tuse_rs_D = T0; wa_E = 5'd0; tnew_E = T2;
        cyc("reg0", 1, 1, 0, 0, 2);
        idle();
        rt_D = 5'd9; tuse_rt_D = T1;
        wa_E = 5'd9; tnew_E = T1;
        cyc("fwd_rt", 1, 1, 0, 0, 2);
        tnew_E = T2;
        cyc("rt_stall", 0, 0, 1, 0, 2);
        idle();
        cyc("rt_clear", 1, 1, 0, 0, 3);

        // Mult with md_D held: busy t..t+5
        md_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b0;
        cyc("mul_t0", 0, 0, 1, 1, 3);
        md_start_E = 1'b0;
        for (int k = 1; k <= 5; k++)
            cyc($sformatf("mul_t%0d", k), 0, 0, 1, 1, 32'(3 + k));
        cyc("mul_t6", 1, 1, 0, 0, 9);
        md_D = 1'b0;

        // Div restart three cycles later
        md_start_E = 1'b1; md_div_E = 1'b1;
        cyc("div_s0", 1, 1, 0, 1, 9);
        md_start_E = 1'b0;
        cyc("div_s1", 1, 1, 0, 1, 9);
        cyc("div_s2", 1, 1, 0, 1, 9);
        md_start_E = 1'b1;
        cyc("div_s3", 1, 1, 0, 1, 9);
        md_start_E = 1'b0;
        for (int k = 4; k <= 13; k++)
            cyc($sformatf("div_s%0d", k), 1, 1, 0, 1, 9);
        cyc("div_s14", 1, 1, 0, 0, 9);

        // Reset mid-div at md_cnt = 7
        md_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b1;
        cyc("rdiv_u0", 0, 0, 1, 1, 9);
        md_start_E = 1'b0;
        for (int k = 1; k <= 3; k++)
            cyc($sformatf("rdiv_u%0d", k), 0, 0, 1, 1, 32'(9 + k));
        reset = 1'b1;
        cyc("rdiv_rst", 1, 1, 1, 1, 13);
        reset = 1'b0;
        cyc("rdiv_after", 1, 1, 0, 0, 0);
        idle();

        // Saturation
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        rs_D = 5'd8; tuse_rs_D = T0;
        wa_E = 5'd8; tnew_E = T2;
        cyc("sat0", 0, 0, 1, 0, 32'hFFFF_FFFD);
        cyc("sat1", 0, 0, 1, 0, 32'hFFFF_FFFE);
        cyc("sat2", 0, 0, 1, 0, 32'hFFFF_FFFF);
        cyc("sat3", 0, 0, 1, 0, 32'hFFFF_FFFF);
        idle();
        cyc("sat_hold", 1, 1, 0, 0, 32'hFFFF_FFFF);

        for (int k = 0; k < 4 && exp_q.size() != 0; k++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0",
                     exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
